// File: rtl/checksum_arbiter_pkg.sv
// Shared types and constants for the incremental IPv4 checksum arbiter.
package checksum_arbiter_pkg;

   localparam int CSUM_W_C = 16;
   localparam int DSCP_W_C = 6;

   typedef enum logic [1:0] {
      CA_IDLE = 2'd0,
      CA_CALC = 2'd1,
      CA_RESP = 2'd2
   } csum_arb_states_e;

endpackage

// File: rtl/checksum_arbiter_if.sv
// Request/grant bundle between header-creator lanes and the shared checksum engine.
interface checksum_arbiter_if
   import checksum_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int CSUM_W  = CSUM_W_C,
   parameter int DSCP_W  = DSCP_W_C
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_i;
   logic [NUM_REQ*CSUM_W-1:0] old_checksum_i;
   logic [NUM_REQ*DSCP_W-1:0] old_dscp_i;
   logic [NUM_REQ*DSCP_W-1:0] new_dscp_i;
   logic [NUM_REQ-1:0]        gnt_o;
   logic [CSUM_W-1:0]         new_checksum_o;
   logic                      busy_o;
   logic [IDX_W-1:0]          owner_o;

   modport master (
      output req_i, old_checksum_i, old_dscp_i, new_dscp_i,
      input  gnt_o, new_checksum_o, busy_o, owner_o
   );

   modport slave (
      input  req_i, old_checksum_i, old_dscp_i, new_dscp_i,
      output gnt_o, new_checksum_o, busy_o, owner_o
   );

endinterface

// File: rtl/checksum_arbiter_incr_core.sv
// RFC1624 incremental checksum update for a DSCP rewrite, fixed 2-cycle latency.
module checksum_incr_core
   import checksum_arbiter_pkg::*;
#(
   parameter int CSUM_W = CSUM_W_C,
   parameter int DSCP_W = DSCP_W_C
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [CSUM_W-1:0] hc,
   input  logic [DSCP_W-1:0] old_dscp,
   input  logic [DSCP_W-1:0] new_dscp,
   output logic              out_valid,
   output logic [CSUM_W-1:0] result
);

   logic [CSUM_W-1:0] m_s;
   logic [CSUM_W-1:0] mp_s;
   logic [CSUM_W+1:0] sum_r;
   logic [CSUM_W:0]   s1_s;
   logic [CSUM_W-1:0] s2_s;
   logic              calc_valid_r;
   logic              out_valid_r;
   logic [CSUM_W-1:0] result_r;

   // DSCP sits in TOS bits [7:2]; version/IHL and ECN cancel out of the delta.
   assign m_s  = CSUM_W'({old_dscp, 2'b00});
   assign mp_s = CSUM_W'({new_dscp, 2'b00});

   // Two end-around-carry folds of the 18-bit one's-complement sum.
   assign s1_s = {1'b0, sum_r[CSUM_W-1:0]} + {{(CSUM_W-1){1'b0}}, sum_r[CSUM_W+1:CSUM_W]};
   assign s2_s = s1_s[CSUM_W-1:0] + {{(CSUM_W-1){1'b0}}, s1_s[CSUM_W]};

   // Stage 1 captures the raw sum, stage 2 the folded and inverted result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_r        <= '0;
         calc_valid_r <= 1'b0;
         out_valid_r  <= 1'b0;
         result_r     <= '0;
      end else begin
         calc_valid_r <= in_valid;
         out_valid_r  <= calc_valid_r;
         if (in_valid) begin
            sum_r <= {2'b00, ~hc} + {2'b00, ~m_s} + {2'b00, mp_s};
         end else begin
            sum_r <= sum_r;
         end
         if (calc_valid_r) begin
            result_r <= ~s2_s;
         end else begin
            result_r <= result_r;
         end
      end
   end

   assign out_valid = out_valid_r;
   assign result    = result_r;

endmodule

// File: rtl/checksum_arbiter.sv
// Round-robin arbiter sharing one incremental checksum engine among NUM_REQ lanes.
module checksum_arbiter
   import checksum_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int CSUM_W  = CSUM_W_C,
   parameter int DSCP_W  = DSCP_W_C,
   localparam int IDX_W  = $clog2(NUM_REQ)
) (
   input  logic               CLK,
   input  logic               reset,
   checksum_arbiter_if.slave  bus
);

   csum_arb_states_e  state_r;
   logic [IDX_W-1:0]  rr_ptr_r;
   logic [IDX_W-1:0]  owner_r;
   logic [NUM_REQ-1:0] gnt_r;
   logic              busy_r;
   logic [IDX_W-1:0]  win_idx_s;
   logic              win_found_s;
   logic              core_in_valid_s;
   logic              core_out_valid_s;
   logic [CSUM_W-1:0] core_result_s;
   logic [CSUM_W-1:0] hc_arr_s   [NUM_REQ];
   logic [DSCP_W-1:0] odscp_arr_s[NUM_REQ];
   logic [DSCP_W-1:0] ndscp_arr_s[NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign hc_arr_s[g]    = bus.old_checksum_i[g*CSUM_W +: CSUM_W];
      assign odscp_arr_s[g] = bus.old_dscp_i[g*DSCP_W +: DSCP_W];
      assign ndscp_arr_s[g] = bus.new_dscp_i[g*DSCP_W +: DSCP_W];
   end

   // Scanning offsets from high to low leaves the nearest set bit at/after ptr.
   function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [IDX_W-1:0]   ptr);
      logic [IDX_W:0]   res;
      logic [IDX_W-1:0] k;
      res = '0;
      k   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         k = IDX_W'((int'(ptr) + i) % NUM_REQ);
         if (req[k]) begin
            res = {1'b1, k};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   assign {win_found_s, win_idx_s} = rr_pick(bus.req_i, rr_ptr_r);
   assign core_in_valid_s = (state_r == CA_IDLE) && win_found_s;

   checksum_incr_core #(
      .CSUM_W (CSUM_W),
      .DSCP_W (DSCP_W)
   ) u_core (
      .clk       (CLK),
      .rst_n     (reset),
      .in_valid  (core_in_valid_s),
      .hc        (hc_arr_s[win_idx_s]),
      .old_dscp  (odscp_arr_s[win_idx_s]),
      .new_dscp  (ndscp_arr_s[win_idx_s]),
      .out_valid (core_out_valid_s),
      .result    (core_result_s)
   );

   // Arbitration FSM: capture winner, wait out the engine, pulse its grant.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_r  <= CA_IDLE;
         rr_ptr_r <= '0;
         owner_r  <= '0;
         gnt_r    <= '0;
         busy_r   <= 1'b0;
      end else begin
         case (state_r)
            CA_IDLE: begin
               gnt_r <= '0;
               if (win_found_s) begin
                  owner_r <= win_idx_s;
                  busy_r  <= 1'b1;
                  state_r <= CA_CALC;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= CA_IDLE;
               end
            end
            CA_CALC: begin
               gnt_r   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_r;
               busy_r  <= 1'b1;
               state_r <= CA_RESP;
            end
            CA_RESP: begin
               gnt_r    <= '0;
               busy_r   <= 1'b0;
               rr_ptr_r <= (owner_r == IDX_W'(NUM_REQ - 1)) ? '0 : owner_r + 1'b1;
               state_r  <= CA_IDLE;
            end
            default: begin
               gnt_r   <= '0;
               busy_r  <= 1'b0;
               state_r <= CA_IDLE;
            end
         endcase
      end
   end

   // Grant and engine result are both registered on the same edge.
   assign bus.gnt_o          = gnt_r & {NUM_REQ{core_out_valid_s}};
   assign bus.new_checksum_o = core_result_s;
   assign bus.busy_o         = busy_r;
   assign bus.owner_o        = owner_r;

endmodule

// File: tb/tb_checksum_arbiter.sv
// Self-checking bench for checksum_arbiter: directed table, corner sequences, random vs model.
module tb_checksum_arbiter;

   localparam int N = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   checksum_arbiter_if #(.NUM_REQ(N), .CSUM_W(16), .DSCP_W(6)) bus ();

   checksum_arbiter #(.NUM_REQ(N), .CSUM_W(16), .DSCP_W(6)) dut (
      .CLK   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [N-1:0] req;
   logic [15:0]  hc_a [N];
   logic [5:0]   od_a [N];
   logic [5:0]   nd_a [N];

   always_comb begin
      bus.req_i          = req;
      bus.old_checksum_i = '0;
      bus.old_dscp_i     = '0;
      bus.new_dscp_i     = '0;
      for (int i = 0; i < N; i++) begin
         bus.old_checksum_i[i*16 +: 16] = hc_a[i];
         bus.old_dscp_i[i*6 +: 6]       = od_a[i];
         bus.new_dscp_i[i*6 +: 6]       = nd_a[i];
      end
   end

   typedef struct {
      logic [N-1:0] req;
      logic [15:0]  hc;
      logic [5:0]   od;
      logic [5:0]   nd;
      logic [N-1:0] gnt;
      logic [15:0]  cs;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: HC' = ~(~HC + ~m + m') with end-around carry folded until it fits.
   function automatic logic [15:0] ref_csum(input logic [15:0] hc, input logic [5:0] od,
                                            input logic [5:0] nd);
      logic [15:0] nhc, nm, mp;
      int unsigned s;
      nhc = ~hc;
      nm  = ~{8'h00, od, 2'b00};
      mp  = {8'h00, nd, 2'b00};
      s   = 32'(nhc) + 32'(nm) + 32'(mp);
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      return ~s[15:0];
   endfunction

   function automatic logic [N-1:0] onehot(input int l);
      logic [N-1:0] one;
      one = 1;
      return one << l;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lane, ng, last, k;
      int free_at, exp_at, exp_lane, model_rr, raised, served;
      logic [N-1:0] req_smp;

      vt[0] = '{4'b0001, 16'h099E, 6'h00, 6'h00, 4'b0001, 16'h099E};
      vt[1] = '{4'b0100, 16'h099E, 6'h04, 6'h00, 4'b0100, 16'h09AE};
      vt[2] = '{4'b0100, 16'h099E, 6'h00, 6'h04, 4'b0100, 16'h098E};
      vt[3] = '{4'b0010, 16'hFFFF, 6'h3F, 6'h00, 4'b0010, 16'h00FC};
      vt[4] = '{4'b0010, 16'h1234, 6'h0A, 6'h15, 4'b0010, 16'h1208};
      vt[5] = '{4'b1000, 16'h0000, 6'h00, 6'h3F, 4'b1000, 16'hFF03};

      req = '0;
      for (int i = 0; i < N; i++) begin
         hc_a[i] = '0; od_a[i] = '0; nd_a[i] = '0;
      end

      tick(); tick();
      chk("rst_gnt", bus.gnt_o, 0);
      chk("rst_cs", bus.new_checksum_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_owner", bus.owner_o, 0);
      reset = 1'b1;
      tick();

      // Directed single-requester vectors: grant exactly two edges after request.
      for (int v = 0; v < 6; v++) begin
         lane = 0;
         for (int i = 0; i < N; i++) if (vt[v].req[i]) lane = i;
         hc_a[lane] = vt[v].hc; od_a[lane] = vt[v].od; nd_a[lane] = vt[v].nd;
         req = vt[v].req;
         tick();
         chk("tbl_gnt_early", bus.gnt_o, 0);
         chk("tbl_busy", bus.busy_o, 1);
         tick();
         chk("tbl_gnt", bus.gnt_o, vt[v].gnt);
         chk("tbl_cs", bus.new_checksum_o, vt[v].cs);
         req = '0;
         tick();
      end

      // All four request, each drops after its grant.
      for (int i = 0; i < N; i++) begin
         hc_a[i] = 16'($urandom); od_a[i] = 6'($urandom); nd_a[i] = 6'($urandom);
      end
      req = '1; ng = 0; last = 0;
      for (int n = 1; n <= 14; n++) begin
         tick();
         if (bus.gnt_o != '0) begin
            chk("t3_gnt", bus.gnt_o, onehot(ng));
            chk("t3_cs", bus.new_checksum_o, ref_csum(hc_a[ng % N], od_a[ng % N], nd_a[ng % N]));
            req = req & ~bus.gnt_o;
            ng++;
            last = n;
         end
      end
      chk("t3_grants", ng, 4);
      chk("t3_last_cycle", last, 11);
      req = '0;

      // Continuous requests for eight jobs: strict rotation, busy low only in idle.
      for (int i = 0; i < N; i++) begin
         hc_a[i] = 16'($urandom); od_a[i] = 6'($urandom); nd_a[i] = 6'($urandom);
      end
      req = '1; k = 0;
      for (int n = 1; n <= 24; n++) begin
         tick();
         chk("t4_busy", bus.busy_o, (n % 3 != 0) ? 1 : 0);
         if (n % 3 == 2) begin
            chk("t4_gnt", bus.gnt_o, onehot(k % N));
            chk("t4_cs", bus.new_checksum_o, ref_csum(hc_a[k % N], od_a[k % N], nd_a[k % N]));
            k++;
         end else begin
            chk("t4_gnt_idle", bus.gnt_o, 0);
         end
         if (n == 23) req = '0;
      end

      // Reset during CALC aborts the job; it is re-served after release.
      hc_a[1] = 16'h1234; od_a[1] = 6'h0A; nd_a[1] = 6'h15;
      req = 4'b0010;
      tick();
      chk("t5_owner_pre", bus.owner_o, 1);
      #2 reset = 1'b0;
      #1;
      chk("t5_rst_gnt", bus.gnt_o, 0);
      chk("t5_rst_busy", bus.busy_o, 0);
      chk("t5_rst_cs", bus.new_checksum_o, 0);
      tick();
      chk("t5_no_gnt", bus.gnt_o, 0);
      #2 reset = 1'b1;
      tick();
      chk("t5_busy", bus.busy_o, 1);
      chk("t5_owner", bus.owner_o, 1);
      tick();
      chk("t5_gnt", bus.gnt_o, 4'b0010);
      chk("t5_cs", bus.new_checksum_o, 16'h1208);
      req = '0;
      tick();

      // Operands and request change after capture; in-flight job unaffected.
      hc_a[3] = 16'h099E; od_a[3] = 6'h04; nd_a[3] = 6'h00;
      req = 4'b1000;
      tick();
      nd_a[3] = 6'h3F;
      req = '0;
      tick();
      chk("t6_gnt", bus.gnt_o, 4'b1000);
      chk("t6_cs", bus.new_checksum_o, 16'h09AE);
      tick();
      chk("t6_hold_cs", bus.new_checksum_o, 16'h09AE);

      // Random traffic against a transaction-level model.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      free_at = 0; exp_at = -1; exp_lane = 0; model_rr = 0; raised = 0; served = 0;
      for (int n = 1; n <= 660; n++) begin
         tick();
         req_smp = req;
         if (exp_at == n) begin
            chk("rnd_gnt", bus.gnt_o, onehot(exp_lane));
            chk("rnd_cs", bus.new_checksum_o,
                ref_csum(hc_a[exp_lane], od_a[exp_lane], nd_a[exp_lane]));
            req[exp_lane] = 1'b0;
            served++;
         end else begin
            chk("rnd_gnt_none", bus.gnt_o, 0);
         end
         if (n >= free_at && req_smp != '0) begin
            exp_lane = -1;
            for (int o = 0; o < N; o++) begin
               if (exp_lane < 0 && req_smp[(model_rr + o) % N]) exp_lane = (model_rr + o) % N;
            end
            chk("rnd_owner", bus.owner_o, exp_lane);
            exp_at   = n + 1;
            free_at  = n + 3;
            model_rr = (exp_lane + 1) % N;
         end
         if (n <= 600) begin
            for (int l = 0; l < N; l++) begin
               if (!req[l] && $urandom_range(0, 3) == 0) begin
                  hc_a[l] = 16'($urandom);
                  od_a[l] = 6'($urandom_range(0, 63));
                  nd_a[l] = 6'($urandom_range(0, 63));
                  req[l]  = 1'b1;
                  raised++;
               end
            end
         end
      end
      chk("rnd_served", served, raised);
      chk("rnd_req_clear", req, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
